// File: rtl/ask4_symbol_slicer.sv
// 4-ASK receive slicer: picks one matched-filter sample per symbol, Gray-decodes it
// against an adaptive threshold. Optional error statistics: ASK4_ERR_STATS_EN.
module ask4_symbol_slicer #(
    parameter int          ACC_LOG2 = 7,
    parameter logic [17:0] INIT_REF = 18'h08000
) (
    input  logic               sys_clk,
    input  logic               reset,
    input  logic               sam_clk_en,
    input  logic               sym_clk_en,
    input  logic        [1:0]  dec_phase,
    input  logic signed [17:0] sig_in,
    output logic        [1:0]  sym_out,
    output logic               sym_valid,
    output logic        [17:0] ref_level,
    output logic               ref_valid,
    output logic        [17:0] err_pwr
);

    localparam int ACC_W = 18 + ACC_LOG2;

    logic        [1:0]          r_phase;
    logic                       r_dec_d;
    logic signed [17:0]         r_x;
    logic        [ACC_W-1:0]    r_acc;
    logic        [ACC_LOG2-1:0] r_cnt;
    logic        [1:0]          r_sym;
    logic                       r_sym_valid;
    logic        [17:0]         r_ref;
    logic                       r_ref_valid;

    logic                       w_dec;
    logic signed [18:0]         w_x_ext;
    logic signed [18:0]         w_r_pos;
    logic signed [18:0]         w_r_neg;
    logic        [1:0]          w_sym;
    logic        [17:0]         w_mag;
    logic        [ACC_W-1:0]    w_acc_sum;
    logic                       w_win_end;
    logic        [17:0]         w_ref_new;

    assign w_dec = sam_clk_en && (r_phase == dec_phase);

    assign w_x_ext = {r_x[17], r_x};
    assign w_r_pos = {1'b0, r_ref};
    assign w_r_neg = -w_r_pos;

    // Gray mapping: 00=-3a, 01=-a, 11=+a, 10=+3a
    always_comb begin
        w_sym = 2'b00;
        if (w_x_ext >= w_r_pos) begin
            w_sym = 2'b10;
        end else if (!r_x[17]) begin
            w_sym = 2'b11;
        end else if (w_x_ext >= w_r_neg) begin
            w_sym = 2'b01;
        end
    end

    // -1.0 has no positive 1s17 counterpart, so it saturates to the largest magnitude
    always_comb begin
        w_mag = r_x;
        if (r_x[17]) begin
            if (r_x[16:0] == 17'd0) begin
                w_mag = 18'h1FFFF;
            end else begin
                w_mag = 18'(-r_x);
            end
        end
    end

    assign w_acc_sum = r_acc + ACC_W'(w_mag);
    assign w_win_end = (r_cnt == '1);
    assign w_ref_new = 18'(w_acc_sum >> ACC_LOG2);

    always_ff @(posedge sys_clk) begin
        if (!reset) begin
            r_phase     <= 2'd0;
            r_dec_d     <= 1'b0;
            r_x         <= '0;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_sym       <= 2'b00;
            r_sym_valid <= 1'b0;
            r_ref       <= INIT_REF;
            r_ref_valid <= 1'b0;
        end else begin
            if (sam_clk_en) begin
                r_phase <= sym_clk_en ? 2'd0 : r_phase + 2'd1;
            end
            r_dec_d     <= w_dec;
            r_sym_valid <= r_dec_d;
            if (w_dec) begin
                r_x <= sig_in;
            end
            // The symbol closing a window is still sliced with the old threshold
            if (r_dec_d) begin
                r_sym <= w_sym;
                if (w_win_end) begin
                    r_acc       <= '0;
                    r_cnt       <= '0;
                    r_ref       <= w_ref_new;
                    r_ref_valid <= 1'b1;
                end else begin
                    r_acc <= w_acc_sum;
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end

    assign sym_out   = r_sym;
    assign sym_valid = r_sym_valid;
    assign ref_level = r_ref;
    assign ref_valid = r_ref_valid;

`ifdef ASK4_ERR_STATS_EN
    logic signed [19:0]      w_half;
    logic signed [19:0]      w_three_half;
    logic signed [19:0]      w_ideal;
    logic signed [19:0]      w_err_wide;
    logic signed [17:0]      w_err;
    logic signed [35:0]      w_sq;
    logic        [17:0]      w_sq_bits;
    logic        [ACC_W-1:0] w_err_sum;
    logic        [ACC_W-1:0] r_err_acc;
    logic        [17:0]      r_err_pwr;

    assign w_half       = $signed({3'b000, r_ref[17:1]});
    assign w_three_half = $signed({2'b00, r_ref}) + w_half;

    always_comb begin
        w_ideal = -w_three_half;
        case (w_sym)
            2'b10:   w_ideal = w_three_half;
            2'b11:   w_ideal = w_half;
            2'b01:   w_ideal = -w_half;
            default: w_ideal = -w_three_half;
        endcase
    end

    assign w_err_wide = {{2{r_x[17]}}, r_x} - w_ideal;

    always_comb begin
        w_err = w_err_wide[17:0];
        if (w_err_wide > 20'sd131071) begin
            w_err = 18'sh1FFFF;
        end else if (w_err_wide < -20'sd131072) begin
            w_err = 18'sh20000;
        end
    end

    assign w_sq      = 36'(w_err) * 36'(w_err);
    assign w_sq_bits = w_sq[34:17];
    assign w_err_sum = r_err_acc + ACC_W'(w_sq_bits);

    always_ff @(posedge sys_clk) begin
        if (!reset) begin
            r_err_acc <= '0;
            r_err_pwr <= '0;
        end else if (r_dec_d) begin
            if (w_win_end) begin
                r_err_acc <= '0;
                r_err_pwr <= 18'(w_err_sum >> ACC_LOG2);
            end else begin
                r_err_acc <= w_err_sum;
            end
        end
    end

    assign err_pwr = r_err_pwr;
`else
    assign err_pwr = 18'd0;
`endif

endmodule

// File: tb/tb_ask4_symbol_slicer.sv
// Directed bench for ask4_symbol_slicer; each sample strobe is followed by 3 idle cycles,
// and sym_clk_en marks the last sample of each 4-sample group.
module tb_ask4_symbol_slicer;

    logic        sys_clk;
    logic        reset;
    logic        sam_clk_en;
    logic        sym_clk_en;
    logic [1:0]  dec_phase;
    logic [17:0] sig_in;
    logic [1:0]  sym_out;
    logic        sym_valid;
    logic [17:0] ref_level;
    logic        ref_valid;
    logic [17:0] err_pwr;

    int checks = 0;
    int errors = 0;

    ask4_symbol_slicer #(
        .ACC_LOG2(7),
        .INIT_REF(18'h08000)
    ) dut (
        .sys_clk   (sys_clk),
        .reset     (reset),
        .sam_clk_en(sam_clk_en),
        .sym_clk_en(sym_clk_en),
        .dec_phase (dec_phase),
        .sig_in    (sig_in),
        .sym_out   (sym_out),
        .sym_valid (sym_valid),
        .ref_level (ref_level),
        .ref_valid (ref_valid),
        .err_pwr   (err_pwr)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    // vpat[i] = sym_valid seen after the i-th edge following the strobe edge
    task automatic send_sample(input logic [17:0] x, input logic sym, output logic [3:0] vpat);
        sig_in     = x;
        sam_clk_en = 1'b1;
        sym_clk_en = sym;
        @(posedge sys_clk);
        #1;
        sam_clk_en = 1'b0;
        sym_clk_en = 1'b0;
        vpat[0]    = sym_valid;
        for (int i = 1; i < 4; i++) begin
            @(posedge sys_clk);
            #1;
            vpat[i] = sym_valid;
        end
    endtask

    task automatic send_group(input logic [17:0] s0, input logic [17:0] s1,
                              input logic [17:0] s2, input logic [17:0] s3,
                              output logic [15:0] vp);
        logic [3:0] p;
        send_sample(s0, 1'b0, p); vp[3:0]   = p;
        send_sample(s1, 1'b0, p); vp[7:4]   = p;
        send_sample(s2, 1'b0, p); vp[11:8]  = p;
        send_sample(s3, 1'b1, p); vp[15:12] = p;
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            sam_clk_en = 1'($urandom);
            sym_clk_en = 1'($urandom);
            dec_phase  = 2'($urandom);
            sig_in     = 18'($urandom);
            @(posedge sys_clk);
            #1;
        end
        sam_clk_en = 1'b0;
        sym_clk_en = 1'b0;
        sig_in     = 18'd0;
        dec_phase  = 2'd0;
        reset      = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            sam_clk_en = 1'($urandom);
            sym_clk_en = 1'($urandom);
            dec_phase  = 2'($urandom);
            sig_in     = 18'($urandom);
            @(posedge sys_clk);
            #1;
        end
        checks++;
        if ({sym_out, sym_valid, ref_valid, err_pwr} !== 22'd0) begin
            errors++;
            $display("FAIL reset_outputs: sym_out=%b sym_valid=%b ref_valid=%b err_pwr=%h required all 0",
                     sym_out, sym_valid, ref_valid, err_pwr);
        end
        checks++;
        if (ref_level !== 18'h08000) begin
            errors++;
            $display("FAIL reset_ref_level: got %h required 08000", ref_level);
        end
        sam_clk_en = 1'b0;
        sym_clk_en = 1'b0;
        sig_in     = 18'd0;
        dec_phase  = 2'd0;
        reset      = 1'b1;
    endtask

    task automatic test_constant();
        logic [15:0] vp;
        apply_reset();
        dec_phase = 2'd0;
        for (int g = 0; g < 3; g++) begin
            send_group(18'h10000, 18'h10000, 18'h10000, 18'h10000, vp);
            checks++;
            if (sym_out !== 2'b10) begin
                errors++;
                $display("FAIL const_pos_sym: got %b required 10", sym_out);
            end
            checks++;
            if (vp !== 16'h0002) begin
                errors++;
                $display("FAIL const_pos_valid_timing: got %h required 0002", vp);
            end
        end
        send_group(18'h3C000, 18'h3C000, 18'h3C000, 18'h3C000, vp);
        checks++;
        if (sym_out !== 2'b01) begin
            errors++;
            $display("FAIL const_neg_sym: got %b required 01", sym_out);
        end
        dec_phase = 2'd3;
        send_group(18'h10000, 18'h10000, 18'h10000, 18'h10000, vp);
        checks++;
        if (sym_out !== 2'b10 || vp !== 16'h2000) begin
            errors++;
            $display("FAIL const_phase3: got sym %b valid %h required 10 / 2000", sym_out, vp);
        end
    endtask

    task automatic test_adaptation();
        logic [15:0] vp;
        logic [17:0] lv_a[4];
        logic [17:0] lv_b[4];
        logic [1:0]  sy[4];
        lv_a = '{18'h34000, 18'h3C000, 18'h04000, 18'h0C000};
        lv_b = '{18'h28000, 18'h38000, 18'h08000, 18'h18000};
        sy   = '{2'b00, 2'b01, 2'b11, 2'b10};
        apply_reset();
        dec_phase = 2'd0;
        for (int g = 0; g < 128; g++) begin
            send_group(lv_a[g%4], lv_a[g%4], lv_a[g%4], lv_a[g%4], vp);
            checks++;
            if (sym_out !== sy[g%4]) begin
                errors++;
                $display("FAIL adapt_a125_sym: group %0d got %b required %b", g, sym_out, sy[g%4]);
            end
            if (g == 126) begin
                checks++;
                if (ref_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL adapt_early_ref_valid: got %b required 0 after 127 symbols", ref_valid);
                end
            end
        end
        checks++;
        if (ref_valid !== 1'b1 || ref_level !== 18'h08000) begin
            errors++;
            $display("FAIL adapt_window1: ref_valid=%b ref_level=%h required 1 / 08000", ref_valid, ref_level);
        end
        for (int g = 0; g < 128; g++) begin
            send_group(lv_b[g%4], lv_b[g%4], lv_b[g%4], lv_b[g%4], vp);
        end
        checks++;
        if (ref_level !== 18'h10000 || ref_valid !== 1'b1) begin
            errors++;
            $display("FAIL adapt_window2: ref_level=%h ref_valid=%b required 10000 / 1", ref_level, ref_valid);
        end
        for (int g = 0; g < 4; g++) begin
            send_group(lv_b[g], lv_b[g], lv_b[g], lv_b[g], vp);
            checks++;
            if (sym_out !== sy[g]) begin
                errors++;
                $display("FAIL adapt_a250_sym: level %0d got %b required %b", g, sym_out, sy[g]);
            end
        end
    endtask

    task automatic test_phase_select();
        logic [15:0] vp;
        logic [3:0]  p1;
        logic [3:0]  p3;
        logic [3:0]  px;
        apply_reset();
        dec_phase = 2'd2;
        send_group(18'h0, 18'h0, 18'h10000, 18'h0, vp);
        checks++;
        if (sym_out !== 2'b10 || vp !== 16'h0200) begin
            errors++;
            $display("FAIL phase2_select: got sym %b valid %h required 10 / 0200", sym_out, vp);
        end
        dec_phase = 2'd1;
        send_group(18'h0, 18'h0, 18'h10000, 18'h0, vp);
        checks++;
        if (sym_out !== 2'b11 || vp !== 16'h0020) begin
            errors++;
            $display("FAIL phase1_select: got sym %b valid %h required 11 / 0020", sym_out, vp);
        end
        send_sample(18'h0, 1'b0, px);
        dec_phase = 2'd3;
        send_sample(18'h0, 1'b0, p1);
        send_sample(18'h0, 1'b0, px);
        send_sample(18'h10000, 1'b1, p3);
        checks++;
        if (p1 !== 4'b0000 || p3 !== 4'b0010 || sym_out !== 2'b10) begin
            errors++;
            $display("FAIL phase_change_midstream: p1=%b p3=%b sym=%b required 0000 / 0010 / 10", p1, p3, sym_out);
        end
    endtask

    task automatic test_saturation();
        logic [15:0] vp;
        apply_reset();
        dec_phase = 2'd0;
        for (int g = 0; g < 128; g++) begin
            send_group(18'h20000, 18'h20000, 18'h20000, 18'h20000, vp);
        end
        checks++;
        if (sym_out !== 2'b00) begin
            errors++;
            $display("FAIL sat_sym: got %b required 00", sym_out);
        end
        checks++;
        if (ref_level !== 18'h1FFFF || ref_valid !== 1'b1) begin
            errors++;
            $display("FAIL sat_ref_level: got %h valid %b required 1FFFF / 1", ref_level, ref_valid);
        end
    endtask

    task automatic test_reset_mid_window();
        logic [15:0] vp;
        apply_reset();
        dec_phase = 2'd0;
        for (int g = 0; g < 60; g++) begin
            send_group(18'h20000, 18'h20000, 18'h20000, 18'h20000, vp);
        end
        apply_reset();
        dec_phase = 2'd0;
        for (int g = 0; g < 127; g++) begin
            send_group(18'h04000, 18'h04000, 18'h04000, 18'h04000, vp);
        end
        checks++;
        if (ref_valid !== 1'b0 || ref_level !== 18'h08000) begin
            errors++;
            $display("FAIL midreset_no_early_update: ref_valid=%b ref_level=%h required 0 / 08000", ref_valid, ref_level);
        end
        send_group(18'h04000, 18'h04000, 18'h04000, 18'h04000, vp);
        checks++;
        if (ref_valid !== 1'b1 || ref_level !== 18'h04000) begin
            errors++;
            $display("FAIL midreset_update: ref_valid=%b ref_level=%h required 1 / 04000", ref_valid, ref_level);
        end
    endtask

    task automatic test_err_stats();
        logic [15:0] vp;
        logic [17:0] lv_i[4];
        logic [17:0] lv_o[4];
        logic [17:0] exp_off;
        lv_i = '{18'h34000, 18'h3C000, 18'h04000, 18'h0C000};
        lv_o = '{18'h34400, 18'h3C400, 18'h04400, 18'h0C400};
`ifdef ASK4_ERR_STATS_EN
        exp_off = 18'h00008;
`else
        exp_off = 18'h00000;
`endif
        apply_reset();
        dec_phase = 2'd0;
        for (int g = 0; g < 128; g++) begin
            send_group(lv_i[g%4], lv_i[g%4], lv_i[g%4], lv_i[g%4], vp);
        end
        checks++;
        if (err_pwr !== 18'h0 || ref_valid !== 1'b1) begin
            errors++;
            $display("FAIL err_ideal: err_pwr=%h ref_valid=%b required 00000 / 1", err_pwr, ref_valid);
        end
        for (int g = 0; g < 128; g++) begin
            send_group(lv_o[g%4], lv_o[g%4], lv_o[g%4], lv_o[g%4], vp);
        end
        checks++;
        if (err_pwr !== exp_off) begin
            errors++;
            $display("FAIL err_offset: err_pwr=%h required %h", err_pwr, exp_off);
        end
        checks++;
        if (ref_level !== 18'h08000 || sym_out !== 2'b10) begin
            errors++;
            $display("FAIL err_offset_ref: ref_level=%h sym=%b required 08000 / 10", ref_level, sym_out);
        end
    endtask

    initial begin
        reset      = 1'b0;
        sam_clk_en = 1'b0;
        sym_clk_en = 1'b0;
        dec_phase  = 2'd0;
        sig_in     = 18'd0;
        test_reset();
        test_constant();
        test_adaptation();
        test_phase_select();
        test_saturation();
        test_reset_mid_window();
        test_err_stats();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
